// File: rtl/key_stream_loader.sv
// Serial key loader: assembles MSB-first key bits plus an even-parity trailer
// and releases the parallel key to the locked circuit only after the check passes.
module key_stream_loader #(
    parameter int KEY_WIDTH = 5,
    parameter int CNT_W     = $clog2(KEY_WIDTH + 1)
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 start,
    input  logic                 ser_valid,
    input  logic                 ser_data,
    output logic                 ser_ready,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 key_valid,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           dbg_state
);

    // ser_ready is asserted in LOAD; a bit moves on any cycle with ser_valid && ser_ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_WIDTH-1:0] sh_q, sh_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 kv_q, kv_d;
    logic                 err_q, err_d;
    logic [KEY_WIDTH-1:0] sh_shift;

    if (KEY_WIDTH == 1) begin : g_one
        assign sh_shift = ser_data;
    end else begin : g_many
        assign sh_shift = {sh_q[KEY_WIDTH-2:0], ser_data};
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            sh_q    <= '0;
            key_q   <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            kv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            kv_q    <= kv_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        key_d   = key_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        kv_d    = kv_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    sh_d    = '0;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    err_d   = 1'b0;
                    key_d   = '0;
                    kv_d    = 1'b0;
                end
            end
            LOAD: begin
                if (ser_valid) begin
                    // The transfer after the last key bit carries the parity trailer.
                    if (cnt_q == CNT_W'(KEY_WIDTH)) begin
                        par_d   = ser_data;
                        state_d = CHECK;
                    end else begin
                        sh_d  = sh_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                if ((^sh_q ^ par_q) == 1'b0) begin
                    key_d   = sh_q;
                    kv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ser_ready = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == CHECK);
    assign key       = key_q;
    assign key_valid = kv_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_key_stream_loader.sv
// Directed bench for key_stream_loader (KEY_WIDTH=5): nominal, parity failure,
// stalls, async reset mid-load, ignored controls and reload from DONE.
module tb_key_stream_loader;

    localparam int KW = 5;
    localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_CHECK = 2'd2, S_DONE = 2'd3;

    logic          C = 1'b0;
    logic          R;
    logic          start, ser_valid, ser_data;
    logic          ser_ready, key_valid, busy, err;
    logic [KW-1:0] key;
    logic [1:0]    dbg_state;

    int total = 0;
    int bad = 0;
    int edges = 0;
    int e0 = 0;
    int ready_cnt = 0;
    int kv_hi = 0;

    key_stream_loader #(.KEY_WIDTH(KW)) dut (
        .C(C), .R(R), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
        .ser_ready(ser_ready), .key(key), .key_valid(key_valid), .busy(busy),
        .err(err), .dbg_state(dbg_state)
    );

    always #5 C = ~C;
    always @(posedge C) edges++;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        e0 = edges;
    endtask

    // bits[5] goes first; bits[0] is the parity trailer. stall[i] inserts one
    // idle cycle before bit i, spulse[i] drives start alongside bit i.
    task automatic load(input logic [5:0] bits, input logic [5:0] stall, input logic [5:0] spulse);
        ready_cnt = 0;
        kv_hi = 0;
        for (int i = 5; i >= 0; i--) begin
            if (stall[i]) begin
                ser_valid = 1'b0;
                start = spulse[i];
                if (ser_ready) ready_cnt++;
                if (key_valid) kv_hi = 1;
                tick();
            end
            ser_valid = 1'b1;
            ser_data = bits[i];
            start = spulse[i];
            if (ser_ready) ready_cnt++;
            if (key_valid) kv_hi = 1;
            tick();
        end
        ser_valid = 1'b0;
        ser_data = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        R = 1'b0; start = 1'b0; ser_valid = 1'b0; ser_data = 1'b0;
        #3;
        check("rst_ready", ser_ready, 0);
        check("rst_key", key, 0);
        check("rst_kv", key_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, S_IDLE);
        @(negedge C);
        R = 1'b1;
        tick();

        // Nominal load 10110 + parity 1
        do_start();
        check("nom_state_load", dbg_state, S_LOAD);
        check("nom_busy", busy, 1);
        check("nom_ready", ser_ready, 1);
        load(6'b101101, 6'b000000, 6'b000000);
        check("nom_state_check", dbg_state, S_CHECK);
        check("nom_check_ready", ser_ready, 0);
        check("nom_check_busy", busy, 1);
        check("nom_check_kv", key_valid, 0);
        check("nom_check_key", key, 0);
        tick();
        check("nom_key", key, 5'b10110);
        check("nom_kv", key_valid, 1);
        check("nom_err", err, 0);
        check("nom_state_done", dbg_state, S_DONE);
        check("nom_busy_done", busy, 0);
        check("nom_latency", edges - e0, 7);
        check("nom_ready_cycles", ready_cnt, 6);

        // ser_valid in DONE is ignored
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'b1;
            ser_data = i[0];
            tick();
        end
        ser_valid = 1'b0;
        check("done_ign_kv", key_valid, 1);
        check("done_ign_key", key, 5'b10110);
        check("done_ign_state", dbg_state, S_DONE);
        check("done_ign_ready", ser_ready, 0);

        // Reload 01101 + parity 1 from DONE
        do_start();
        check("reload_kv_drop", key_valid, 0);
        check("reload_key_drop", key, 0);
        load(6'b011011, 6'b000000, 6'b000000);
        check("reload_kv_low_during_load", kv_hi, 0);
        check("reload_check_kv", key_valid, 0);
        tick();
        check("reload_key", key, 5'b01101);
        check("reload_kv", key_valid, 1);

        // Parity failure: 10110 + parity 0
        do_start();
        load(6'b101100, 6'b000000, 6'b000000);
        tick();
        check("pf_err", err, 1);
        check("pf_key", key, 0);
        check("pf_kv", key_valid, 0);
        check("pf_state", dbg_state, S_IDLE);
        check("pf_busy", busy, 0);

        // ser_valid in IDLE is ignored
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'b1;
            ser_data = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
        check("idle_ign_state", dbg_state, S_IDLE);
        check("idle_ign_ready", ser_ready, 0);
        check("idle_ign_err", err, 1);

        // Restart clears err; stalls (incl. before parity) and start pulses in LOAD
        do_start();
        check("pf_err_cleared", err, 0);
        load(6'b101101, 6'b010001, 6'b001010);
        check("stall_state_check", dbg_state, S_CHECK);
        tick();
        check("stall_key", key, 5'b10110);
        check("stall_kv", key_valid, 1);
        check("stall_latency", edges - e0, 9);
        check("stall_ready_cycles", ready_cnt, 8);

        // Async reset after 3 bits of a new load
        do_start();
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'b1;
            ser_data = 1'b1;
            tick();
        end
        ser_valid = 1'b0;
        check("mid_state_load", dbg_state, S_LOAD);
        #2;
        R = 1'b0;
        #1;
        check("mr_ready", ser_ready, 0);
        check("mr_busy", busy, 0);
        check("mr_key", key, 0);
        check("mr_kv", key_valid, 0);
        check("mr_state", dbg_state, S_IDLE);
        @(negedge C);
        R = 1'b1;
        tick();
        do_start();
        load(6'b011011, 6'b000000, 6'b000000);
        tick();
        check("mr_reload_key", key, 5'b01101);
        check("mr_reload_kv", key_valid, 1);
        check("mr_reload_latency", edges - e0, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
